isa_ofifo_arbiter: RTL

Arbitrates the ISA-side event sources (IDE 170h/171h, OPL3 388h–38Bh, MIDI 330h, GUS 342h–347h) onto the single write port of the FPGA→Pi output ring buffer. Each source posts an atomic {port, data} transaction. The block writes it as two contiguous 9-bit entries, a port marker `{1, port[7:0]}` followed by a data word `{0, data[7:0]}`, so pairs from different sources never interleave. The block owns the write and read pointers, applies backpressure when the ring cannot take a full pair, and drives the "FIFO has data" indication toward the Pi.

---
 rtl/isa_ofifo_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/isa_ofifo_arbiter.sv
// Round-robin arbiter that writes atomic {port marker, data} pairs from the ISA
// event sources into the FPGA->Pi ring buffer and owns its read/write pointers.
module isa_ofifo_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_port,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              flush,
  input  logic              rd_inc,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [8:0]        wr_data,
  output logic [AW-1:0]     rd_addr,
  output logic              not_empty,
  output logic [AW-1:0]     level
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW-1:0] ONE      = {{(AW-1){1'b0}}, 1'b1};
  // Largest occupancy that still leaves two free slots (2^AW - 3).
  localparam logic [AW-1:0] ROOM_MAX = {{(AW-2){1'b1}}, 2'b01};
  localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WA = 2'd1, WD = 2'd2} state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   wp, rp, wp_nx, rp_nx;
  logic [IW-1:0]   last, last_nx, win, win_nx, pick;
  logic [7:0]      lat_port, lat_data, port_nx, data_nx;
  logic [7:0]      port_arr [NREQ];
  logic [7:0]      data_arr [NREQ];
  logic [NREQ-1:0] cand, ready_nx;
  logic            found, room, wr_en_nx, ne_nx;
  logic [AW-1:0]   wr_addr_nx, level_nx;
  logic [8:0]      wr_data_nx;

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign port_arr[g] = req_port[8*g +: 8];
    assign data_arr[g] = req_data[8*g +: 8];
  end

  assign room = ((wp - rp) <= ROOM_MAX);

  // Round-robin search after the last winner; the source acknowledged this
  // cycle is still showing its old request, so it is masked out.
  always_comb begin
    cand  = req_valid & ~req_ready;
    found = 1'b0;
    pick  = last;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && cand[IW'((int'(last) + k) % NREQ)]) begin
        found = 1'b1;
        pick  = IW'((int'(last) + k) % NREQ);
      end else begin
        found = found;
      end
    end
  end

  // Pair-writer FSM, pointer updates and next values of the registered outputs
  always_comb begin
    state_nx   = state;
    wp_nx      = wp;
    last_nx    = last;
    win_nx     = win;
    port_nx    = lat_port;
    data_nx    = lat_data;
    wr_en_nx   = 1'b0;
    wr_addr_nx = wr_addr;
    wr_data_nx = wr_data;
    ready_nx   = '0;
    if (rd_inc && (wp != rp)) begin
      rp_nx = rp + ONE;
    end else begin
      rp_nx = rp;
    end
    case (state)
      IDLE, WD: begin
        if (found && room) begin
          win_nx     = pick;
          port_nx    = port_arr[pick];
          data_nx    = data_arr[pick];
          wr_en_nx   = 1'b1;
          wr_addr_nx = wp;
          wr_data_nx = {1'b1, port_arr[pick]};
          wp_nx      = wp + ONE;
          state_nx   = WA;
        end else begin
          state_nx   = IDLE;
        end
      end
      WA: begin
        wr_en_nx      = 1'b1;
        wr_addr_nx    = wp;
        wr_data_nx    = {1'b0, lat_data};
        wp_nx         = wp + ONE;
        ready_nx[win] = 1'b1;
        last_nx       = win;
        state_nx      = WD;
      end
      default: state_nx = IDLE;
    endcase
    // Occupancy reported from the pointer covering writes already on the bus.
    if (flush) begin
      state_nx   = IDLE;
      wp_nx      = '0;
      rp_nx      = '0;
      last_nx    = last;
      wr_en_nx   = 1'b0;
      wr_addr_nx = '0;
      wr_data_nx = 9'h000;
      ready_nx   = '0;
      level_nx   = '0;
      ne_nx      = 1'b0;
    end else begin
      level_nx   = wp - rp_nx;
      ne_nx      = (wp != rp_nx);
    end
  end

  // State, pointers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wp        <= '0;
      rp        <= '0;
      last      <= LAST_RST;
      win       <= '0;
      lat_port  <= 8'h00;
      lat_data  <= 8'h00;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 9'h000;
      req_ready <= '0;
      rd_addr   <= '0;
      not_empty <= 1'b0;
      level     <= '0;
    end else begin
      state     <= state_nx;
      wp        <= wp_nx;
      rp        <= rp_nx;
      last      <= last_nx;
      win       <= win_nx;
      lat_port  <= port_nx;
      lat_data  <= data_nx;
      wr_en     <= wr_en_nx;
      wr_addr   <= wr_addr_nx;
      wr_data   <= wr_data_nx;
      req_ready <= ready_nx;
      rd_addr   <= rp_nx;
      not_empty <= ne_nx;
      level     <= level_nx;
    end
  end
endmodule
